pipelined_addsub_n: RTL and testbench
=====================================

// Module: pipelined_addsub_n
// PURPOSE
//  Parametrised, pipelined ripple-carry adder/subtractor for the datapath ALU.
//  Splits a WIDTH-bit add/sub into WIDTH/CHUNK ripple slices, one slice per pipeline stage.
//  Each stage registers its carry into the next, so clock rate is set by one CHUNK-bit ripple.
//  Valid/ready handshake on both sides with full backpressure. Sits between operand fetch and writeback.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; must be a multiple of CHUNK
//  CHUNK  8   bits rippled per stage; NSTG = WIDTH/CHUNK stages (= latency)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      a, b, sub qualify this cycle
//  in_ready   out  1      block accepts operands this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  sub        in   1      0: a+b; 1: a-b (computed as a + ~b + 1)
//  out_valid  out  1      result fields qualify this cycle
//  out_ready  in   1      downstream accepts result
//  o          out  WIDTH  sum/difference
//  co         out  1      carry out of MSB (for sub: 1 = no borrow)
//  ovf        out  1      signed two's-complement overflow
// BEHAVIOUR
//  - Reset (async, rst=1): all stage valid bits, out_valid, o, co, ovf clear to 0; in-flight ops discarded.
//  - Global advance: adv = !out_valid | out_ready; in_ready = adv. All stages shift together on adv.
//  - Accept: in_valid & in_ready -> stage 0 captures a, b^{WIDTH{sub}}, sub as carry-in, sub flag.
//  - Stage k (0..NSTG-1): ripples bits [k*CHUNK +: CHUNK] with registered carry from stage k-1
//    (stage 0 uses sub); upper operand bits and lower result bits travel alongside in skew registers.
//  - Latency: exactly NSTG cycles from accept to out_valid with no backpressure; throughput 1/cycle.
//  - Bubbles: a stage holding no valid op still shifts; valid bits mark occupancy only.
//  - Backpressure: out_valid & !out_ready freezes every stage; o/co/ovf held stable until taken.
//  - co = carry out of bit WIDTH-1; ovf = carry into MSB XOR carry out of MSB.
//  - Wrap-around: results are modulo 2^WIDTH (0xFFFF+0x0001 -> 0x0000, co=1, ovf=0).
//  - Simultaneous accept and retire in one cycle: both occur; no bubble inserted.
//  - out_valid, o, co, ovf are registered outputs; in_ready is combinational from out_valid/out_ready.
//  - WIDTH % CHUNK != 0: elaboration error via generate-time check.
// CONFIGURATION
//  ADDSUB_SAT_EN defined: final stage clamps on ovf; positive overflow -> 0x7F..F,
//    negative overflow -> 0x80..0; ovf still reports 1; co unchanged; latency unchanged.
//  ADDSUB_SAT_EN undefined: o is the raw wrapped result; no clamp logic instantiated.
// TESTING (WIDTH=16, CHUNK=8 unless noted)
//  1. a=0x00FF, b=0x0001, sub=0, out_ready=1 -> 2 cycles later o=0x0100, co=0, ovf=0 (inter-stage carry).
//  2. a=0x0000, b=0x0001, sub=1 -> o=0xFFFF, co=0, ovf=0; a=0x0005, b=0x0003, sub=1 -> o=0x0002, co=1.
//  3. a=0x7FFF, b=0x0001, sub=0 -> o=0x8000, ovf=1; with ADDSUB_SAT_EN -> o=0x7FFF, ovf=1.
//  4. Back-to-back 4 ops, out_ready=0 from cycle 3 for 3 cycles -> outputs frozen, in_ready=0,
//     no op lost or duplicated; order preserved after release.
//  5. rst pulsed mid-flight with 2 ops inside -> out_valid=0 immediately, no stale result afterward.
//  6. WIDTH=32, CHUNK=8: random 1000 ops vs golden model, random stalls -> latency 4, all match.

Source files
------------

// File: rtl/pipelined_addsub_n.sv
// Pipelined ripple-carry adder/subtractor.
// WIDTH/CHUNK stages, each rippling CHUNK bits, with a registered carry into the next stage.
// Define ADDSUB_SAT_EN to clamp the final result on signed overflow. When it is undefined,
// o is the raw result modulo 2^WIDTH.
module pipelined_addsub_n #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic             co,
  output logic             ovf
);

  localparam int unsigned NSTG = WIDTH / CHUNK;

  logic             adv;
  logic [WIDTH-1:0] b_eff;

  // Every stage advances together whenever the output register is free or being drained.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign b_eff    = b ^ {WIDTH{sub}};

  if (WIDTH % CHUNK != 0) begin : g_bad_cfg
    $error("pipelined_addsub_n: WIDTH must be a multiple of CHUNK");
  end

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    logic [CHUNK-1:0] ca;
    logic [CHUNK-1:0] cb;
    logic             ci;
    logic             vin;
    logic [CHUNK:0]   sum;

    // Stage 0 takes its chunk straight from the ports. Later stages take the lowest
    // chunk of the previous stage's skewed operand registers.
    if (k == 0) begin : g_in
      assign ca  = a[CHUNK-1:0];
      assign cb  = b_eff[CHUNK-1:0];
      assign ci  = sub;
      assign vin = in_valid;
    end else begin : g_in
      assign ca  = g_stg[k-1].g_mid.aq[CHUNK-1:0];
      assign cb  = g_stg[k-1].g_mid.bq[CHUNK-1:0];
      assign ci  = g_stg[k-1].g_mid.cq;
      assign vin = g_stg[k-1].g_mid.vq;
    end

    assign sum = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, ci};

    if (k < NSTG - 1) begin : g_mid
      localparam int unsigned UPW = WIDTH - (k + 1) * CHUNK;
      localparam int unsigned RW  = (k + 1) * CHUNK;

      logic [UPW-1:0] aq, bq, an, bn;
      logic [RW-1:0]  rq, rn;
      logic           cq, vq;

      // The skew registers shrink by one chunk per stage. Operand bits not yet consumed
      // ride ahead, and finished result bits ride behind.
      if (k == 0) begin : g_src
        assign an = a[WIDTH-1:CHUNK];
        assign bn = b_eff[WIDTH-1:CHUNK];
        assign rn = sum[CHUNK-1:0];
      end else begin : g_src
        assign an = g_stg[k-1].g_mid.aq[UPW+CHUNK-1:CHUNK];
        assign bn = g_stg[k-1].g_mid.bq[UPW+CHUNK-1:CHUNK];
        assign rn = {sum[CHUNK-1:0], g_stg[k-1].g_mid.rq};
      end

      // Intermediate stage register: shifts on adv, including bubbles.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          aq <= '0;
          bq <= '0;
          rq <= '0;
          cq <= 1'b0;
          vq <= 1'b0;
        end else if (adv) begin
          aq <= an;
          bq <= bn;
          rq <= rn;
          cq <= sum[CHUNK];
          vq <= vin;
        end
      end
    end else begin : g_last
      logic [WIDTH-1:0] res;
      logic [WIDTH-1:0] res_out;
      logic             cm;
      logic             ov;

      if (k == 0) begin : g_res
        assign res = sum[CHUNK-1:0];
      end else begin : g_res
        assign res = {sum[CHUNK-1:0], g_stg[k-1].g_mid.rq};
      end

      // Carry into the MSB is recovered from the MSB's sum bit and its operand bits.
      assign cm = ca[CHUNK-1] ^ cb[CHUNK-1] ^ sum[CHUNK-1];
      assign ov = cm ^ sum[CHUNK];

`ifdef ADDSUB_SAT_EN
      // Clamp on overflow. A carry-out of 1 with overflow means both operands were negative.
      always_comb begin
        res_out = res;
        if (ov) begin
          res_out = sum[CHUNK] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
      end
`else
      assign res_out = res;
`endif

      // The output register is the last pipeline stage.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_valid <= 1'b0;
          o         <= '0;
          co        <= 1'b0;
          ovf       <= 1'b0;
        end else if (adv) begin
          out_valid <= vin;
          o         <= res_out;
          co        <= sum[CHUNK];
          ovf       <= ov;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_addsub_n.sv
// Directed bench for pipelined_addsub_n. It uses a 16/8 instance and a 32/8 instance.
// Saturation expectations follow ADDSUB_SAT_EN.
module tb_pipelined_addsub_n;

`ifdef ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid, in_ready, sub, out_valid, out_ready, co, ovf;
  logic [15:0] a, b, o;
  logic        w_in_valid, w_in_ready, w_sub, w_out_valid, w_out_ready, w_co, w_ovf;
  logic [31:0] w_a, w_b, w_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipelined_addsub_n #(.WIDTH(16), .CHUNK(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .o(o), .co(co), .ovf(ovf)
  );

  pipelined_addsub_n #(.WIDTH(32), .CHUNK(8)) u_wide (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .a(w_a), .b(w_b),
    .sub(w_sub), .out_valid(w_out_valid), .out_ready(w_out_ready), .o(w_o), .co(w_co), .ovf(w_ovf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0;
    w_in_valid = 1'b0; w_out_ready = 1'b1; w_a = '0; w_b = '0; w_sub = 1'b0;
    #2 rst = 1'b1;
    #2;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if (o !== 16'h0000) begin fails++; $display("FAIL reset_o got %h want 0000", o); end
    tests++; if ({co, ovf} !== 2'b00) begin fails++; $display("FAIL reset_co_ovf got %b want 00", {co, ovf}); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_addsub();
    logic [15:0] va [7] = '{16'h00FF, 16'h0000, 16'h0005, 16'h7FFF, 16'hFFFF, 16'h8000, 16'h1234};
    logic [15:0] vb [7] = '{16'h0001, 16'h0001, 16'h0003, 16'h0001, 16'h0001, 16'h0001, 16'h4321};
    logic        vs [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] eo [7] = '{16'h0100, 16'hFFFF, 16'h0002, SAT ? 16'h7FFF : 16'h8000,
                            16'h0000, SAT ? 16'h8000 : 16'h7FFF, 16'h5555};
    logic        ec [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        ev [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      a = va[i]; b = vb[i]; sub = vs[i]; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL addsub[%0d]_early_valid got %b want 0", i, out_valid); end
      step();
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL addsub[%0d]_valid got %b want 1", i, out_valid); end
      tests++; if (o !== eo[i]) begin fails++; $display("FAIL addsub[%0d]_o got %h want %h", i, o, eo[i]); end
      tests++; if (co !== ec[i]) begin fails++; $display("FAIL addsub[%0d]_co got %b want %b", i, co, ec[i]); end
      tests++; if (ovf !== ev[i]) begin fails++; $display("FAIL addsub[%0d]_ovf got %b want %b", i, ovf, ev[i]); end
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [4] = '{16'h0001, 16'h00FF, 16'h0010, 16'h7000};
    logic [15:0] vb [4] = '{16'h0002, 16'h0101, 16'h0020, 16'h1000};
    logic        vs [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] eo [4] = '{16'h0003, 16'h0200, 16'hFFF0, SAT ? 16'h7FFF : 16'h8000};
    logic        ec [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic        ev [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int sent = 0;
    int got  = 0;
    for (int c = 0; c < 14; c++) begin
      out_ready = !(c >= 3 && c < 6);
      in_valid  = (sent < 4);
      if (sent < 4) begin a = va[sent]; b = vb[sent]; sub = vs[sent]; end
      #1;
      if (out_valid === 1'b1) begin
        if (got >= 4) begin
          tests++; fails++; $display("FAIL b2b_extra_result got %h want none", o);
        end else if (out_ready) begin
          tests++; if (o !== eo[got] || co !== ec[got] || ovf !== ev[got]) begin
            fails++; $display("FAIL b2b_result[%0d] got %h/%b/%b want %h/%b/%b", got, o, co, ovf, eo[got], ec[got], ev[got]);
          end
          got++;
        end else begin
          tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_stall_in_ready c%0d got %b want 0", c, in_ready); end
          tests++; if (o !== eo[got]) begin fails++; $display("FAIL b2b_stall_hold c%0d got %h want %h", c, o, eo[got]); end
        end
      end
      if (in_valid && in_ready) sent++;
      step();
    end
    in_valid = 1'b0;
    tests++; if (got !== 4) begin fails++; $display("FAIL b2b_count got %0d want 4", got); end
    tests++; if (sent !== 4) begin fails++; $display("FAIL b2b_sent got %0d want 4", sent); end
    out_ready = 1'b1;
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1;
    a = 16'h0001; b = 16'h0001; sub = 1'b0; in_valid = 1'b1;
    step();
    a = 16'h0002; b = 16'h0002;
    step();
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rstmid_pre_valid got %b want 1", out_valid); end
    #2 rst = 1'b1;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid got %b want 0", out_valid); end
    tests++; if (o !== 16'h0000) begin fails++; $display("FAIL rstmid_o got %h want 0000", o); end
    #1 rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_stale c%0d got %b want 0", c, out_valid); end
    end
  endtask

  task automatic test_wide();
    logic [31:0] va [4] = '{32'h00FF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF};
    logic [31:0] vb [4] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'hFFFF_FFFF};
    logic        vs [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] eo [4] = '{32'h0100_0000, SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    logic        ec [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic        ev [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int lat;
    w_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w_a = va[i]; w_b = vb[i]; w_sub = vs[i]; w_in_valid = 1'b1;
      step();
      w_in_valid = 1'b0;
      lat = 1;
      while (w_out_valid !== 1'b1 && lat < 8) begin
        step();
        lat++;
      end
      tests++; if (lat !== 4) begin fails++; $display("FAIL wide[%0d]_latency got %0d want 4", i, lat); end
      tests++; if (w_o !== eo[i] || w_co !== ec[i] || w_ovf !== ev[i]) begin
        fails++; $display("FAIL wide[%0d]_result got %h/%b/%b want %h/%b/%b", i, w_o, w_co, w_ovf, eo[i], ec[i], ev[i]);
      end
    end
    step();
  endtask

  initial begin
    test_reset();
    test_addsub();
    test_back_to_back();
    test_reset_midflight();
    test_wide();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
